// File: rtl/branch_predictor.sv
// Branch predictor: a table of 2-bit saturating counters indexed by the
// fetch PC, trained by branches resolving in execute. Also keeps
// saturating counts of resolved and mispredicted branches.
// Define GSHARE_EN to XOR a global taken/not-taken history into the
// table index. Without it, the table is indexed by PC bits alone.
//
// Handshake: none. Fetch lookups are purely combinational. An update is
// accepted on any rising edge where ex_branch_valid=1 and stall=0.
module branch_predictor #(
    parameter int BHT_INDEX_BITS = 4,
    parameter int PC_WIDTH       = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [PC_WIDTH-1:0]       if_pc,
    input  logic                      if_is_branch,
    output logic                      if_predict_taken,
    output logic [BHT_INDEX_BITS-1:0] if_bht_index,
    input  logic                      ex_branch_valid,
    input  logic [BHT_INDEX_BITS-1:0] ex_bht_index,
    input  logic                      ex_predicted_taken,
    input  logic                      ex_actual_taken,
    input  logic                      stall,
    output logic                      Wrong_prediction,
    output logic [15:0]               stat_branches,
    output logic [15:0]               stat_mispredicts
);

    localparam int ENTRIES = 1 << BHT_INDEX_BITS;

    logic [1:0]  bht_q [ENTRIES];
    logic [1:0]  bht_d [ENTRIES];
    logic [15:0] branches_q, branches_d;
    logic [15:0] mispredicts_q, mispredicts_d;

    logic        update_en;
    logic        wrong_raw;
    logic        unused_pc_bits;

    // Only the low PC bits feed the index; the rest are deliberately ignored.
    assign unused_pc_bits = ^if_pc[PC_WIDTH-1:BHT_INDEX_BITS];

    assign update_en = ex_branch_valid & ~stall;
    assign wrong_raw = ex_branch_valid & (ex_predicted_taken != ex_actual_taken);

`ifdef GSHARE_EN
    logic [BHT_INDEX_BITS-1:0] hist_q, hist_d;

    // Global history: shift the resolved outcome in at the LSB on each update.
    always_comb begin
        hist_d = hist_q;
        if (update_en) begin
            hist_d = {hist_q[BHT_INDEX_BITS-2:0], ex_actual_taken};
        end
    end

    // History register, cleared asynchronously.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hist_q <= '0;
        end else begin
            hist_q <= hist_d;
        end
    end

    assign if_bht_index = if_pc[BHT_INDEX_BITS-1:0] ^ hist_q;
`else
    assign if_bht_index = if_pc[BHT_INDEX_BITS-1:0];
`endif

    // Fetch sees the registered counter, so a same-cycle update is not bypassed.
    assign if_predict_taken = rst & if_is_branch & bht_q[if_bht_index][1];
    // Misprediction is reported even while stalled; only updates are held.
    assign Wrong_prediction = rst & wrong_raw;
    assign stat_branches    = branches_q;
    assign stat_mispredicts = mispredicts_q;

    // Train the addressed counter toward the resolved outcome, saturating.
    always_comb begin
        bht_d = bht_q;
        if (update_en) begin
            if (ex_actual_taken) begin
                if (bht_q[ex_bht_index] != 2'b11) begin
                    bht_d[ex_bht_index] = bht_q[ex_bht_index] + 2'b01;
                end
            end else begin
                if (bht_q[ex_bht_index] != 2'b00) begin
                    bht_d[ex_bht_index] = bht_q[ex_bht_index] - 2'b01;
                end
            end
        end
    end

    // Saturating statistics counters.
    always_comb begin
        branches_d    = branches_q;
        mispredicts_d = mispredicts_q;
        if (update_en) begin
            if (branches_q != 16'hFFFF) begin
                branches_d = branches_q + 16'd1;
            end
            if (wrong_raw && (mispredicts_q != 16'hFFFF)) begin
                mispredicts_d = mispredicts_q + 16'd1;
            end
        end
    end

    // Table and statistics registers; reset puts every entry at weak-not-taken.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                bht_q[i] <= 2'b01;
            end
            branches_q    <= '0;
            mispredicts_q <= '0;
        end else begin
            for (int i = 0; i < ENTRIES; i++) begin
                bht_q[i] <= bht_d[i];
            end
            branches_q    <= branches_d;
            mispredicts_q <= mispredicts_d;
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor (default parameters).
// A reference model predicts the outputs for each driven cycle; the
// prediction is queued and compared against the DUT mid-cycle.
module tb_branch_predictor;

    localparam int IB = 4;
    localparam int W  = 38;  // {pred, idx[3:0], wrong, branches[15:0], mispredicts[15:0]}

    logic          clk = 1'b0;
    logic          rst;
    logic [31:0]   if_pc;
    logic          if_is_branch;
    logic          if_predict_taken;
    logic [IB-1:0] if_bht_index;
    logic          ex_branch_valid;
    logic [IB-1:0] ex_bht_index;
    logic          ex_predicted_taken;
    logic          ex_actual_taken;
    logic          stall;
    logic          Wrong_prediction;
    logic [15:0]   stat_branches;
    logic [15:0]   stat_mispredicts;

    // Clock
    always #5 clk = ~clk;

    branch_predictor #(.BHT_INDEX_BITS(IB), .PC_WIDTH(32)) dut (
        .clk                (clk),
        .rst                (rst),
        .if_pc              (if_pc),
        .if_is_branch       (if_is_branch),
        .if_predict_taken   (if_predict_taken),
        .if_bht_index       (if_bht_index),
        .ex_branch_valid    (ex_branch_valid),
        .ex_bht_index       (ex_bht_index),
        .ex_predicted_taken (ex_predicted_taken),
        .ex_actual_taken    (ex_actual_taken),
        .stall              (stall),
        .Wrong_prediction   (Wrong_prediction),
        .stat_branches      (stat_branches),
        .stat_mispredicts   (stat_mispredicts)
    );

    // Reference model state
    logic [1:0]    m_tab [16];
    logic [IB-1:0] m_hist;
    logic [15:0]   m_br;
    logic [15:0]   m_mp;

    // Scoreboard
    logic [W-1:0] exp_q[$];
    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_tab[i] = 2'b01;
        m_hist = '0;
        m_br   = '0;
        m_mp   = '0;
    endtask

    task automatic model_update(input logic [IB-1:0] idx, input logic ep, input logic ea);
        if (ea && m_tab[idx] != 2'b11) m_tab[idx] = m_tab[idx] + 2'b01;
        if (!ea && m_tab[idx] != 2'b00) m_tab[idx] = m_tab[idx] - 2'b01;
        m_hist = {m_hist[IB-2:0], ea};
        if (m_br != 16'hFFFF) m_br = m_br + 16'd1;
        if ((ep != ea) && m_mp != 16'hFFFF) m_mp = m_mp + 16'd1;
    endtask

    // Predict the outputs for the inputs currently driven and queue them.
    task automatic push_expect();
        logic [IB-1:0] idx;
        logic          pred;
        logic          wrong;
        logic [IB-1:0] pc_lo;
        pc_lo = if_pc[IB-1:0];
`ifdef GSHARE_EN
        idx = pc_lo ^ m_hist;
`else
        idx = pc_lo;
`endif
        pred  = rst & if_is_branch & m_tab[idx][1];
        wrong = rst & ex_branch_valid & (ex_predicted_taken != ex_actual_taken);
        exp_q.push_back({pred, idx, wrong, m_br, m_mp});
    endtask

    task automatic compare_now();
        logic [W-1:0] e;
        if (exp_q.size() == 0) begin
            check_eq("queue_empty", 32'd1, 32'd0);
            return;
        end
        e = exp_q.pop_front();
        check_eq("if_predict_taken", {31'd0, if_predict_taken}, {31'd0, e[37]});
        check_eq("if_bht_index", {28'd0, if_bht_index}, {28'd0, e[36:33]});
        check_eq("Wrong_prediction", {31'd0, Wrong_prediction}, {31'd0, e[32]});
        check_eq("stat_branches", {16'd0, stat_branches}, {16'd0, e[31:16]});
        check_eq("stat_mispredicts", {16'd0, stat_mispredicts}, {16'd0, e[15:0]});
    endtask

    // Drive one cycle (called at posedge+1), check mid-cycle, commit model at the edge.
    task automatic step(input logic ib, input logic [31:0] pc, input logic ev,
                        input logic [IB-1:0] ei, input logic ep, input logic ea,
                        input logic st);
        if_is_branch       = ib;
        if_pc              = pc;
        ex_branch_valid    = ev;
        ex_bht_index       = ei;
        ex_predicted_taken = ep;
        ex_actual_taken    = ea;
        stall              = st;
        push_expect();
        @(negedge clk);
        compare_now();
        if (ev && !st) model_update(ei, ep, ea);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        if_is_branch = 1'b0; if_pc = '0; ex_branch_valid = 1'b0; ex_bht_index = '0;
        ex_predicted_taken = 1'b0; ex_actual_taken = 1'b0; stall = 1'b0;
    endtask

    initial begin
        // Reset
        rst = 1'b0;
        idle_inputs();
        model_reset();
        #3;
        push_expect();
        compare_now();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Fresh predictor: weak-NT everywhere, stats zero.
        step(1, 32'h5, 0, 0, 0, 0, 0);
        // Resolve idx 5 taken but predicted NT; fetch of pc 5 still sees pre-update value.
        step(1, 32'h5, 1, 4'd5, 0, 1, 0);
        step(1, 32'h5, 0, 0, 0, 0, 0);
        // Non-branch fetch never predicts taken.
        step(0, 32'h5, 0, 0, 0, 0, 0);

        // Saturation on index 3: four taken, then walk down with not-taken.
        for (int i = 0; i < 4; i++) step(1, 32'h3, 1, 4'd3, 1, 1, 0);
        for (int i = 0; i < 5; i++) step(1, 32'h13, 1, 4'd3, 1, 0, 0);
        step(1, 32'h3, 1, 4'd3, 0, 1, 0);
        step(1, 32'h3, 0, 0, 0, 0, 0);

        // Stall with a mispredicted branch: flag visible, nothing updates.
        step(1, 32'h7, 1, 4'd7, 0, 1, 1);
        step(1, 32'h7, 1, 4'd7, 1, 0, 1);
        step(1, 32'h7, 0, 0, 0, 0, 0);

        // Taken, taken, not-taken then fetch pc 0 (history-dependent index when enabled).
        step(1, 32'h0, 1, 4'd1, 0, 1, 0);
        step(1, 32'h0, 1, 4'd2, 1, 1, 0);
        step(1, 32'h0, 1, 4'd9, 1, 0, 0);
        step(1, 32'h0, 0, 0, 0, 0, 0);

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            step(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 3) != 0),
                 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 4) == 0));
        end

        // Reset mid-burst: outputs clear immediately, without a clock edge.
        if_is_branch = 1'b1; if_pc = 32'h3; ex_branch_valid = 1'b1; ex_bht_index = 4'd3;
        ex_predicted_taken = 1'b0; ex_actual_taken = 1'b1; stall = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        push_expect();
        compare_now();
        @(posedge clk);
        #1;
        push_expect();
        compare_now();
        idle_inputs();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        step(1, 32'h3, 0, 0, 0, 0, 0);
        step(1, 32'h3, 1, 4'd3, 0, 1, 0);
        step(1, 32'h3, 0, 0, 0, 0, 0);

        if (exp_q.size() != 0) check_eq("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 Parameter BHT_INDEX_BITS, default 4: number of bits used to index the branch history table (2^BHT_INDEX_BITS entries).
REQ-002 Parameter PC_WIDTH, default 32: program counter width in bits.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 if_pc  input  PC_WIDTH  PC of the instruction currently in fetch.
REQ-006 if_is_branch  input  1  fetch-stage predecode flags a conditional branch (beq/bne).
REQ-007 if_predict_taken  output  1  prediction for the fetch-stage branch; 0 when if_is_branch=0.
REQ-008 if_bht_index  output  BHT_INDEX_BITS  table index used for this prediction, carried down the pipeline.
REQ-009 ex_branch_valid  input  1  a resolved conditional branch is in the execute stage this cycle.
REQ-010 ex_bht_index  input  BHT_INDEX_BITS  index returned from the pipeline for the resolving branch.
REQ-011 ex_predicted_taken  input  1  prediction carried with the resolving branch.
REQ-012 ex_actual_taken  input  1  resolved branch outcome.
REQ-013 stall  input  1  pipeline hold; blocks all table, history and statistics updates.
REQ-014 Wrong_prediction  output  1  misprediction flag feeding the branch resolver's PC-source selection.
REQ-015 stat_branches  output  16  count of resolved branches.
REQ-016 stat_mispredicts  output  16  count of mispredictions.

Function
REQ-017 The block SHALL hold a table of 2^BHT_INDEX_BITS 2-bit saturating counters: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
REQ-018 if_bht_index SHALL be the index computed as defined under Configuration, with if_pc[BHT_INDEX_BITS-1:0] as the base index.
REQ-019 if_predict_taken SHALL be combinational: if_is_branch AND bit 1 of counter[if_bht_index]; zero-cycle latency.
REQ-020 Wrong_prediction SHALL be combinational: ex_branch_valid AND (ex_predicted_taken != ex_actual_taken), independent of stall.
REQ-021 On a rising edge with ex_branch_valid=1 and stall=0, counter[ex_bht_index] SHALL increment if ex_actual_taken=1 and decrement otherwise, saturating at 11 and 00.
REQ-022 A same-cycle read and write to one entry SHALL return the pre-update value to fetch (no bypass); the update is visible next cycle.
REQ-023 stat_branches SHALL increment on every qualifying update (REQ-021); stat_mispredicts SHALL also increment when Wrong_prediction=1; both saturate at 16'hFFFF.
REQ-024 With stall=1 or ex_branch_valid=0, all state SHALL hold its value.
REQ-025 Entries other than ex_bht_index SHALL never change during operation.

Reset
REQ-026 While rst=0, all counters SHALL be forced to 01 (weak-NT), history to 0, and both statistics to 0, asynchronously.
REQ-027 While rst=0, Wrong_prediction and if_predict_taken SHALL be 0.
REQ-028 Deassertion of rst mid-operation SHALL discard all in-flight state; the first edge after release behaves as a clean start.

Configuration
REQ-029 Macro GSHARE_EN SHALL select the indexing scheme.
REQ-030 With GSHARE_EN defined, a BHT_INDEX_BITS-wide global history register SHALL shift in ex_actual_taken at LSB on each qualifying update (REQ-021), and the index SHALL be if_pc[BHT_INDEX_BITS-1:0] XOR history.
REQ-031 Without GSHARE_EN, no history register SHALL exist, and the index SHALL be if_pc[BHT_INDEX_BITS-1:0].

Verification
REQ-032 Reset, then if_pc=0x5, if_is_branch=1 -> if_predict_taken=0, if_bht_index=5, stats=0.
REQ-033 Resolve index 5 with actual=1 and predicted=0 -> Wrong_prediction=1 in the same cycle; next cycle counter[5]=10, if_predict_taken=1 for pc 0x5, stat_mispredicts=1.
REQ-034 Resolve index 3 taken four times (no GSHARE_EN) -> counter[3] saturates at 11 and stays there; four not-taken resolves -> reaches 00 and saturates.
REQ-035 stall=1 held with ex_branch_valid=1 -> Wrong_prediction still reflects the inputs; table, history and statistics are unchanged.
REQ-036 GSHARE_EN defined, resolve taken, taken, not-taken -> history=3'b110 in the low bits; fetch of if_pc=0x0 reports if_bht_index=4'b0110.
REQ-037 Assert rst low mid-burst of updates -> all outputs go to reset values immediately without a clock edge; stat_branches=0 after release.
